// File: rtl/stream_serializer.sv
// Wide-to-narrow stream serializer: emits one IN_LANES-lane word as IN_LANES
// narrow beats, lane 0 first, reloading on the last beat so full-rate input has no bubbles.
module stream_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_LANES   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IN_LANES*DATA_WIDTH-1:0] data_in,
    input  logic                           data_in_valid,
    output logic                           data_in_ready,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           data_out_valid,
    input  logic                           data_out_ready,
    output logic                           data_out_last
);

    localparam int CW = $clog2(IN_LANES);
    localparam logic [CW-1:0] LAST_LANE = CW'(IN_LANES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                         state_q;
    logic [CW-1:0]                  lane_cnt_q;
    logic [IN_LANES*DATA_WIDTH-1:0] word_q;

    logic in_xfer;
    logic out_xfer;

    assign data_out_valid = (state_q == SEND);
    assign data_out_last  = data_out_valid && (lane_cnt_q == LAST_LANE);
    // A new word can enter on the very cycle the last lane of the current word leaves.
    assign data_in_ready  = !rst && ((state_q == IDLE) || (data_out_last && data_out_ready));
    assign in_xfer        = data_in_valid && data_in_ready;
    assign out_xfer       = data_out_valid && data_out_ready;

    always_comb begin
        data_out = '0;
        for (int i = 0; i < IN_LANES; i++) begin
            if (lane_cnt_q == CW'(i)) begin
                data_out = word_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        word_q     <= data_in;
                        lane_cnt_q <= '0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (out_xfer) begin
                        if (lane_cnt_q != LAST_LANE) begin
                            lane_cnt_q <= lane_cnt_q + CW'(1);
                        end else if (in_xfer) begin
                            word_q     <= data_in;
                            lane_cnt_q <= '0;
                        end else begin
                            lane_cnt_q <= '0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    lane_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Directed and scoreboard-checked bench for stream_serializer (4x8 and 3x4 configurations).
module tb_stream_serializer;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] a_din;
    logic        a_dv;
    logic        a_dr;
    logic [7:0]  a_do;
    logic        a_ov;
    logic        a_or;
    logic        a_last;

    logic [11:0] b_din;
    logic        b_dv;
    logic        b_dr;
    logic [3:0]  b_do;
    logic        b_ov;
    logic        b_or;
    logic        b_last;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_serializer #(.DATA_WIDTH(8), .IN_LANES(4)) u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .data_in       (a_din),
        .data_in_valid (a_dv),
        .data_in_ready (a_dr),
        .data_out      (a_do),
        .data_out_valid(a_ov),
        .data_out_ready(a_or),
        .data_out_last (a_last)
    );

    stream_serializer #(.DATA_WIDTH(4), .IN_LANES(3)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .data_in       (b_din),
        .data_in_valid (b_dv),
        .data_in_ready (b_dr),
        .data_out      (b_do),
        .data_out_valid(b_ov),
        .data_out_ready(b_or),
        .data_out_last (b_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    logic [7:0]  exp1 [4];
    logic [31:0] words2 [3];
    logic [7:0]  sb_q [$];
    logic [7:0]  sb_e;
    logic [7:0]  prev_do;
    logic        prev_stall;
    int          sent;
    int          popped;

    initial begin
        exp1   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        words2 = '{32'h03020100, 32'h07060504, 32'h0B0A0908};

        rst = 1'b1;
        a_din = '0; a_dv = 1'b0; a_or = 1'b0;
        b_din = '0; b_dv = 1'b0; b_or = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", a_dr, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_data_out", a_do, 0);
        chk("rst_last", a_last, 0);
        chk("rst_b_out_valid", b_ov, 0);
        @(negedge clk);

        // single word
        rst = 1'b0;
        a_din = 32'hDDCCBBAA; a_dv = 1'b1; a_or = 1'b1;
        #1;
        chk("t1_in_ready_after_rst", a_dr, 1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            a_dv = 1'b0; a_din = 32'h12345678;
            #1;
            chk("t1_valid", a_ov, 1);
            chk("t1_data", a_do, exp1[k]);
            chk("t1_last", a_last, (k == 3));
            @(negedge clk);
        end
        #1;
        chk("t1_valid_after", a_ov, 0);
        @(negedge clk);

        // back-to-back words
        for (int k = 0; k < 14; k++) begin
            a_dv = (k < 12);
            a_din = words2[(k < 12) ? (k / 4) : 2];
            a_or = 1'b1;
            #1;
            chk("t2_in_ready", a_dr, ((k % 4) == 0) || (k == 13));
            if (k >= 1 && k <= 12) begin
                chk("t2_valid", a_ov, 1);
                chk("t2_data", a_do, k - 1);
                chk("t2_last", a_last, ((k % 4) == 0));
            end else if (k == 13) begin
                chk("t2_valid_after", a_ov, 0);
            end
            @(negedge clk);
        end

        // backpressure on lane 1
        a_din = 32'hDDCCBBAA; a_dv = 1'b1; a_or = 1'b1;
        @(negedge clk);
        a_dv = 1'b0; a_din = 32'h5A5A5A5A;
        #1;
        chk("t3_lane0", a_do, 8'hAA);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            a_or = 1'b0; a_dv = 1'b1;
            #1;
            chk("t3_stall_valid", a_ov, 1);
            chk("t3_stall_data", a_do, 8'hBB);
            chk("t3_stall_in_ready", a_dr, 0);
            @(negedge clk);
        end
        a_dv = 1'b0;
        for (int k = 1; k < 4; k++) begin
            a_or = 1'b1;
            #1;
            chk("t3_resume_data", a_do, exp1[k]);
            chk("t3_resume_last", a_last, (k == 3));
            @(negedge clk);
        end
        #1;
        chk("t3_valid_after", a_ov, 0);
        @(negedge clk);

        // non-power-of-two lanes
        b_din = 12'h321; b_dv = 1'b1; b_or = 1'b1;
        #1;
        chk("t4_in_ready", b_dr, 1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            b_dv = 1'b0; b_din = 12'hFFF;
            #1;
            chk("t4_valid", b_ov, 1);
            chk("t4_data", b_do, k + 1);
            chk("t4_last", b_last, (k == 2));
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t4_no_fourth", b_ov, 0);
            @(negedge clk);
        end

        // reset mid-word
        a_din = 32'hDDCCBBAA; a_dv = 1'b1; a_or = 1'b1;
        @(negedge clk);
        a_dv = 1'b0;
        #1;
        chk("t5_lane0", a_do, 8'hAA);
        @(negedge clk);
        #1;
        chk("t5_lane1", a_do, 8'hBB);
        @(negedge clk);
        rst = 1'b1; a_dv = 1'b1; a_din = 32'hEEEEEEEE;
        #1;
        chk("t5_rst_in_ready", a_dr, 0);
        @(negedge clk);
        rst = 1'b0; a_din = 32'h44332211; a_dv = 1'b1;
        #1;
        chk("t5_post_rst_valid", a_ov, 0);
        chk("t5_post_rst_in_ready", a_dr, 1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            a_dv = 1'b0;
            #1;
            chk("t5_valid", a_ov, 1);
            chk("t5_data", a_do, 8'h11 * (k + 1));
            chk("t5_last", a_last, (k == 3));
            @(negedge clk);
        end
        #1;
        chk("t5_valid_after", a_ov, 0);
        @(negedge clk);

        // random stress against a lane scoreboard
        sent = 0;
        popped = 0;
        prev_stall = 1'b0;
        prev_do = '0;
        for (int cyc = 0; cyc < 60000 && !(sent == 1000 && sb_q.size() == 0); cyc++) begin
            a_dv = (sent < 1000) && ($urandom_range(0, 1) == 1);
            a_din = $urandom();
            a_or = ($urandom_range(0, 1) == 1);
            #1;
            if (prev_stall) begin
                chk("sb_stall_valid", a_ov, 1);
                chk("sb_stall_data", a_do, prev_do);
            end
            if (a_dv && a_dr) begin
                for (int i = 0; i < 4; i++) sb_q.push_back(a_din[i*8 +: 8]);
                sent++;
            end
            if (a_ov && a_or) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra_beat", 1, 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_data", a_do, sb_e);
                    chk("sb_last", a_last, ((popped % 4) == 3));
                    popped++;
                end
            end
            prev_stall = a_ov && !a_or;
            prev_do = a_do;
            @(negedge clk);
        end
        chk("sb_words_sent", sent, 1000);
        chk("sb_beats", popped, 4000);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_serializer.md
# stream_serializer

- Converts a wide valid/ready stream of `IN_LANES` packed lanes into a narrow valid/ready stream carrying one lane per beat, lane 0 first.
- Is the transmit-side counterpart to the lane deserializer. It sits between a wide producer, typically a `fifo` read port, and a narrow consumer.
- Holds one wide word in a register. It accepts the next word on the same cycle the last lane of the current word is taken, so a continuous input stream produces no bubbles.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of one lane and of `data_out`.
- `IN_LANES`, default 4: lanes per input word. Must be ≥ 2; need not be a power of two.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `data_in`, in, `IN_LANES*DATA_WIDTH`: packed word. Lane i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `data_in_valid`, in, 1: `data_in` is valid.
- `data_in_ready`, out, 1: the block accepts `data_in` this cycle.
- `data_out`, out, `DATA_WIDTH`: current lane.
- `data_out_valid`, out, 1: `data_out` is valid.
- `data_out_ready`, in, 1: the consumer takes `data_out` this cycle.
- `data_out_last`, out, 1: asserted with the beat carrying lane `IN_LANES-1`.

## Operation
State:
- `word_reg`: the held wide word.
- `lane_cnt`: lane counter, `$clog2(IN_LANES)` bits.
- FSM with two states, IDLE and SEND.

Handshake definitions:
- Input transfer = `data_in_valid && data_in_ready`.
- Output transfer = `data_out_valid && data_out_ready`.

IDLE:
- `data_out_valid` = 0 and `data_in_ready` = 1.
- On an input transfer: load `word_reg`, set `lane_cnt` to 0, go to SEND.

SEND:
- `data_out_valid` = 1.
- `data_out` = lane `lane_cnt` of `word_reg`.
- `data_out_last` = (`lane_cnt == IN_LANES-1`).
- Output transfer with `lane_cnt < IN_LANES-1`: increment `lane_cnt`.
- Output transfer on the last lane with an input transfer in the same cycle: load the new word, set `lane_cnt` to 0, stay in SEND.
- Output transfer on the last lane with no input transfer: go to IDLE and reset `lane_cnt` to 0.

Ready and output rules:
- `data_in_ready` = `!rst && (state==IDLE || (data_out_last && data_out_ready))`.
- `data_in_ready` has a combinational path from `data_out_ready`; consumers must not make `data_out_ready` depend on `data_in_ready`.
- While `data_out_valid` is high and `data_out_ready` is low, `data_out`, `data_out_last` and `lane_cnt` hold.
- Once asserted, `data_out_valid` does not drop until a transfer occurs.
- `data_out_valid` is never asserted in IDLE.

Boundaries:
- `lane_cnt` wraps explicitly at `IN_LANES-1`; no power-of-two wrap. It never reaches `IN_LANES`, so `IN_LANES=3` emits exactly 3 beats.
- `data_in` is sampled only on an input transfer. Changes on `data_in` at other times have no effect.
- Reset during SEND aborts the word:
  - the remaining lanes are discarded;
  - the state goes to IDLE the next cycle;
  - nothing is emitted from the aborted word.
- Reset overrides any simultaneous transfer.
- No ordering change and no drop or duplication: every accepted word appears as exactly `IN_LANES` beats in lane order.

## Timing
Reset values, in effect the cycle after `rst` is sampled high:
- state IDLE, `lane_cnt` 0, `word_reg` 0;
- `data_out_valid` 0, `data_out_last` 0, `data_out` 0;
- `data_in_ready` 0 while `rst` is high, 1 on the first cycle after release.

Latency and throughput:
- Latency: word accepted at edge t gives lane 0 valid in cycle t+1.
- Throughput: with `data_out_ready` held high and `data_in_valid` held high, one lane per cycle with no idle cycle between words. `data_in_ready` pulses once every `IN_LANES` cycles.

## Test plan
- Single word, default params. Send `data_in=32'hDDCCBBAA`, `data_out_ready=1`. Required:
  - `data_out` = AA, BB, CC, DD on four consecutive cycles starting one cycle after acceptance;
  - `data_out_last` high only with DD;
  - `data_out_valid` low the following cycle.
- Back-to-back. Three words `32'h03020100`, `32'h07060504`, `32'h0B0A0908` with valid held high and ready high. Required:
  - 12 contiguous beats 00..0B with no gap;
  - `data_in_ready` high on cycles 0, 4, 8 relative to the first acceptance.
- Backpressure. Drop `data_out_ready` for 3 cycles while lane 1 (BB) is presented. Required:
  - `data_out` stays BB with valid high throughout;
  - `data_in_ready` stays 0;
  - the sequence resumes CC, DD.
- Non-power-of-two. `IN_LANES=3`, `DATA_WIDTH=4`, `data_in=12'h321`. Required: beats 1, 2, 3, with `data_out_last` on 3, then IDLE; no fourth beat.
- Reset mid-word. Assert `rst` for 1 cycle after lane 1 transfers. Required:
  - next cycle `data_out_valid=0`, `data_in_ready=1`;
  - a following word `32'h44332211` emits 11, 22, 33, 44 with no residual lanes.
- Random stress. Random valid and ready at 50%, 1000 words, checked against a scoreboard. Required: exact lane order, no loss or duplication, and `data_out` stable under stall.
